// File: rtl/obstacle_scanner_pkg.sv
// Shared constants, state encoding and packed-bus slot offsets for the obstacle scanner.
package obstacle_scanner_pkg;

  localparam int unsigned N_OBS = 6;
  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 16;

  // Per-slot stride on the packed obstacle_x / obstacle_y buses.
  localparam int unsigned X_STRIDE = X_W;
  localparam int unsigned Y_STRIDE = Y_W;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StScan   = 2'd1,
    StReport = 2'd2
  } state_e;

  function automatic int unsigned x_lsb(input int unsigned slot);
    return slot * X_STRIDE;
  endfunction

  function automatic int unsigned y_lsb(input int unsigned slot);
    return slot * Y_STRIDE;
  endfunction

endpackage

// File: rtl/obstacle_scanner_if.sv
// Frame request, obstacle/player bus and hit-report handshake of the obstacle scanner.
interface obstacle_scanner_if #(
  parameter int unsigned N_OBS = obstacle_scanner_pkg::N_OBS
);
  import obstacle_scanner_pkg::*;

  logic                   start;
  logic [N_OBS-1:0]       obstacle_on;
  logic [X_W*N_OBS-1:0]   obstacle_x;
  logic [Y_W*N_OBS-1:0]   obstacle_y;
  logic [X_W-1:0]         player_x;
  logic [Y_W-1:0]         player_y;
  logic                   busy;
  logic                   hit_valid;
  logic [IDX_W-1:0]       hit_index;
  logic                   hit_ack;
  logic [CNT_W-1:0]       dodge_count;

  modport master (
    output start, obstacle_on, obstacle_x, obstacle_y, player_x, player_y, hit_ack,
    input  busy, hit_valid, hit_index, dodge_count
  );

  modport slave (
    input  start, obstacle_on, obstacle_x, obstacle_y, player_x, player_y, hit_ack,
    output busy, hit_valid, hit_index, dodge_count
  );

endinterface

// File: rtl/obstacle_overlap.sv
// Combinational overlap / passed test of one obstacle against the player car.
module obstacle_overlap
  import obstacle_scanner_pkg::*;
#(
  parameter int unsigned CAR_W = 8,
  parameter int unsigned CAR_H = 16
) (
  input  logic [X_W-1:0] ox,
  input  logic [Y_W-1:0] oy,
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  output logic           overlap,
  output logic           passed
);

  localparam logic [X_W:0] CarWLim = (X_W+1)'(CAR_W);
  localparam logic [Y_W:0] CarHLim = (Y_W+1)'(CAR_H);

  logic [X_W:0] dx, adx;
  logic [Y_W:0] dy, ady, py_lim;

  // One extra bit keeps the difference from wrapping at the screen edges.
  always_comb begin
    dx      = {1'b0, ox} - {1'b0, px};
    dy      = {1'b0, oy} - {1'b0, py};
    adx     = dx[X_W] ? (~dx + 1'b1) : dx;
    ady     = dy[Y_W] ? (~dy + 1'b1) : dy;
    py_lim  = {1'b0, py} + CarHLim;
    overlap = (adx < CarWLim) && (ady < CarHLim);
    passed  = ({1'b0, oy} > py_lim);
  end

endmodule

// File: rtl/obstacle_scanner.sv
// Per-frame sequential scan of obstacle slots: reports collisions one at a time and counts dodges.
module obstacle_scanner
  import obstacle_scanner_pkg::*;
#(
  parameter int unsigned N_OBS = obstacle_scanner_pkg::N_OBS,
  parameter int unsigned CAR_W = 8,
  parameter int unsigned CAR_H = 16
) (
  input logic               clk,
  input logic               rst_n,
  obstacle_scanner_if.slave sif
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_OBS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [X_W-1:0]   px_q, px_d;
  logic [Y_W-1:0]   py_q, py_d;
  logic             busy_q, busy_d;
  logic             hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0] hit_index_q, hit_index_d;
  logic [CNT_W-1:0] dodge_q, dodge_d;
  logic [N_OBS-1:0] hit_flag_q, hit_flag_d;
  logic [N_OBS-1:0] pass_flag_q, pass_flag_d;

  logic [N_OBS-1:0] slot_sel;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic             sel_on, sel_hit_flag, sel_pass_flag;
  logic             overlap, passed;

  always_comb begin
    slot_sel      = '0;
    sel_x         = '0;
    sel_y         = '0;
    sel_on        = 1'b0;
    sel_hit_flag  = 1'b0;
    sel_pass_flag = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slot_sel[i]   = 1'b1;
        sel_x         = sif.obstacle_x[x_lsb(i) +: X_W];
        sel_y         = sif.obstacle_y[y_lsb(i) +: Y_W];
        sel_on        = sif.obstacle_on[i];
        sel_hit_flag  = hit_flag_q[i];
        sel_pass_flag = pass_flag_q[i];
      end
    end
  end

  obstacle_overlap #(
    .CAR_W (CAR_W),
    .CAR_H (CAR_H)
  ) u_overlap (
    .ox      (sel_x),
    .oy      (sel_y),
    .px      (px_q),
    .py      (py_q),
    .overlap (overlap),
    .passed  (passed)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    px_d        = px_q;
    py_d        = py_q;
    hit_valid_d = hit_valid_q;
    hit_index_d = hit_index_q;
    dodge_d     = dodge_q;
    // A slot that goes inactive is free for respawn in every state.
    hit_flag_d  = hit_flag_q & sif.obstacle_on;
    pass_flag_d = pass_flag_q & sif.obstacle_on;

    unique case (state_q)
      StIdle: begin
        if (sif.start) begin
          px_d    = sif.player_x;
          py_d    = sif.player_y;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (sel_on && overlap && !sel_hit_flag) begin
          hit_flag_d  = hit_flag_d | slot_sel;
          hit_valid_d = 1'b1;
          hit_index_d = idx_q;
          state_d     = StReport;
        end else begin
          if (sel_on && passed && !sel_hit_flag && !sel_pass_flag) begin
            pass_flag_d = pass_flag_d | slot_sel;
            if (dodge_q != '1) dodge_d = dodge_q + 1'b1;
          end
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StReport: begin
        if (sif.hit_ack) begin
          hit_valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StScan;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      busy_q      <= 1'b0;
      hit_valid_q <= 1'b0;
      hit_index_q <= '0;
      dodge_q     <= '0;
      hit_flag_q  <= '0;
      pass_flag_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      px_q        <= px_d;
      py_q        <= py_d;
      busy_q      <= busy_d;
      hit_valid_q <= hit_valid_d;
      hit_index_q <= hit_index_d;
      dodge_q     <= dodge_d;
      hit_flag_q  <= hit_flag_d;
      pass_flag_q <= pass_flag_d;
    end
  end

  assign sif.busy        = busy_q;
  assign sif.hit_valid   = hit_valid_q;
  assign sif.hit_index   = hit_index_q;
  assign sif.dodge_count = dodge_q;

endmodule

// File: tb/tb_obstacle_scanner.sv
// Directed bench for obstacle_scanner: scan timing, hit handshake, suppression, dodges, reset.
module tb_obstacle_scanner;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  obstacle_scanner_if #(.N_OBS(6)) bus();

  obstacle_scanner #(
    .N_OBS (6),
    .CAR_W (8),
    .CAR_H (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input bit on, input logic [7:0] x, input logic [9:0] y);
    bus.obstacle_on[s]          = on;
    bus.obstacle_x[s*8 +: 8]    = x;
    bus.obstacle_y[s*10 +: 10]  = y;
  endtask

  task automatic set_player(input logic [7:0] x, input logic [9:0] y);
    bus.player_x = x;
    bus.player_y = y;
  endtask

  task automatic clear_all();
    bus.obstacle_on = '0;
    step();
  endtask

  // Full scan with immediate acknowledge of any report; returns the last reported slot.
  task automatic run_scan(input string tag, output bit seen, output logic [2:0] idx);
    int k;
    seen = 1'b0;
    idx  = '0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (k = 0; k < 40; k++) begin
      if (!bus.busy) break;
      if (bus.hit_valid) begin
        seen        = 1'b1;
        idx         = bus.hit_index;
        bus.hit_ack = 1'b1;
        step();
        bus.hit_ack = 1'b0;
      end else begin
        step();
      end
    end
    check({tag, "_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit         seen;
    logic [2:0] idx;
    int         cycles;

    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.hit_ack     = 1'b0;
    bus.obstacle_on = '0;
    bus.obstacle_x  = '0;
    bus.obstacle_y  = '0;
    set_player(8'd0, 10'd0);

    step();
    step();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_hit_valid", 32'(bus.hit_valid), 32'd0);
    check("rst_hit_index", 32'(bus.hit_index), 32'd0);
    check("rst_dodge", 32'(bus.dodge_count), 32'd0);
    rst_n = 1'b1;
    step();

    // No-hit scan: busy for exactly six cycles.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cycles = 0;
    seen   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.busy) break;
      cycles++;
      if (bus.hit_valid) seen = 1'b1;
      step();
    end
    check("nohit_busy_cycles", 32'(cycles), 32'd6);
    check("nohit_no_report", 32'(seen), 32'd0);
    check("nohit_dodge", 32'(bus.dodge_count), 32'd0);

    // Single hit on slot 3, reported on the 5th cycle after start.
    set_player(8'd44, 10'd110);
    set_slot(3, 1'b1, 8'd40, 10'd100);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    check("hit_not_early", 32'(bus.hit_valid), 32'd0);
    step();
    check("hit_valid", 32'(bus.hit_valid), 32'd1);
    check("hit_index", 32'(bus.hit_index), 32'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_valid", 32'(bus.hit_valid), 32'd1);
      check("hold_index", 32'(bus.hit_index), 32'd3);
      check("hold_busy", 32'(bus.busy), 32'd1);
    end
    bus.hit_ack = 1'b1;
    step();
    bus.hit_ack = 1'b0;
    check("ack_drops_valid", 32'(bus.hit_valid), 32'd0);
    step();
    check("ack_still_busy", 32'(bus.busy), 32'd1);
    step();
    check("ack_scan_end", 32'(bus.busy), 32'd0);

    // Repeat suppression, then respawn re-arms the slot.
    run_scan("rep1", seen, idx);
    check("rep1_no_report", 32'(seen), 32'd0);
    run_scan("rep2", seen, idx);
    check("rep2_no_report", 32'(seen), 32'd0);
    set_slot(3, 1'b0, 8'd40, 10'd100);
    step();
    set_slot(3, 1'b1, 8'd40, 10'd100);
    run_scan("respawn", seen, idx);
    check("respawn_report", 32'(seen), 32'd1);
    check("respawn_index", 32'(idx), 32'd3);

    // Dodges and saturation.
    clear_all();
    set_player(8'd44, 10'd100);
    set_slot(0, 1'b1, 8'd40, 10'd200);
    run_scan("dodge1", seen, idx);
    check("dodge1_no_report", 32'(seen), 32'd0);
    check("dodge1_count", 32'(bus.dodge_count), 32'd1);
    run_scan("dodge2", seen, idx);
    run_scan("dodge3", seen, idx);
    check("dodge_no_recount", 32'(bus.dodge_count), 32'd1);
    force dut.dodge_q = 16'hFFFE;
    #1;
    release dut.dodge_q;
    check("preload", 32'(bus.dodge_count), 32'h0000_FFFE);
    set_slot(0, 1'b0, 8'd40, 10'd200);
    step();
    set_slot(0, 1'b1, 8'd40, 10'd200);
    set_slot(1, 1'b1, 8'd60, 10'd300);
    run_scan("sat", seen, idx);
    check("sat_count", 32'(bus.dodge_count), 32'h0000_FFFF);

    // Window boundaries and no wrap-around.
    clear_all();
    set_player(8'd40, 10'd100);
    set_slot(2, 1'b1, 8'd48, 10'd100);
    run_scan("dx8", seen, idx);
    check("dx8_no_hit", 32'(seen), 32'd0);
    set_slot(2, 1'b1, 8'd47, 10'd100);
    run_scan("dx7", seen, idx);
    check("dx7_hit", 32'(seen), 32'd1);
    check("dx7_index", 32'(idx), 32'd2);
    clear_all();
    set_player(8'd0, 10'd100);
    set_slot(2, 1'b1, 8'd255, 10'd100);
    run_scan("wrap", seen, idx);
    check("wrap_no_hit", 32'(seen), 32'd0);
    clear_all();
    set_player(8'd40, 10'd100);
    set_slot(4, 1'b1, 8'd40, 10'd116);
    run_scan("dy16", seen, idx);
    check("dy16_no_hit", 32'(seen), 32'd0);
    set_slot(4, 1'b1, 8'd40, 10'd115);
    run_scan("dy15", seen, idx);
    check("dy15_hit", 32'(seen), 32'd1);
    check("dy15_index", 32'(idx), 32'd4);

    // Reset while a report is pending.
    clear_all();
    set_player(8'd44, 10'd110);
    set_slot(1, 1'b1, 8'd40, 10'd100);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.hit_valid) break;
      step();
    end
    check("pre_reset_valid", 32'(bus.hit_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.hit_valid), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_index", 32'(bus.hit_index), 32'd0);
    check("mid_rst_dodge", 32'(bus.dodge_count), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check("post_rst_no_report", 32'(bus.hit_valid), 32'd0);
    check("post_rst_idle", 32'(bus.busy), 32'd0);
    run_scan("post_rst", seen, idx);
    check("post_rst_hit", 32'(seen), 32'd1);
    check("post_rst_index", 32'(idx), 32'd1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
